// File: rtl/dmem_ctrl_s_pkg.sv
// Shared constants and access helpers for the data-memory controller.
// Holds funct3 size codes, the controller state enum and the byte-lane functions.
package dmem_ctrl_s_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Misaligned or undefined size code; unsigned sizes are load-only.
  function automatic logic f_bad(input logic st, input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    f_bad = 1'b0;
      F3_H:    f_bad = a[0];
      F3_W:    f_bad = |a;
      F3_BU:   f_bad = st;
      F3_HU:   f_bad = st | a[0];
      default: f_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   f_be = 4'b0001 << a;
      2'b01:   f_be = a[1] ? 4'b1100 : 4'b0011;
      default: f_be = 4'b1111;
    endcase
  endfunction

  // Replicate low-aligned store data so every candidate lane carries it.
  function automatic logic [31:0] f_lane(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   f_lane = {4{d[7:0]}};
      2'b01:   f_lane = {2{d[15:0]}};
      default: f_lane = d;
    endcase
  endfunction

  function automatic logic [31:0] f_ext(input logic [2:0] f3, input logic [1:0] a,
                                        input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (f3)
      F3_B:    f_ext = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   f_ext = {24'd0, sh[7:0]};
      F3_H:    f_ext = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   f_ext = {16'd0, sh[15:0]};
      default: f_ext = w;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_s.sv
// DEPTH x 32 data RAM: synchronous byte-enabled write, registered read.
module dmem_ram_s #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_q
);
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  // Read returns the pre-write word; the controller never loads and stores in one access.
  always_ff @(posedge clk) begin
    if (i_we)
      for (int b = 0; b < 4; b++)
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    r_q <= r_mem[i_idx];
  end

  assign o_q = r_q;
endmodule

// File: rtl/dmem_ctrl_s.sv
// Data-memory controller: fixed-latency load/store with sub-word access,
// alignment/illegal-size error reporting and a stall handshake to the requester.
module dmem_ctrl_s
  import dmem_ctrl_s_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_st;
  logic [2:0]  r_f3;
  logic [31:0] r_addr, r_wdata, r_rdata;

  logic        w_req, w_accept, w_commit, w_st, w_bad, w_unused_addr;
  logic [2:0]  w_f3;
  logic [31:0] w_addr, w_wdata, w_q, w_ld;

  assign w_req    = mem_read | mem_write;
  assign w_accept = (r_state == S_IDLE) && w_req;

  // Live request feeds the datapath in IDLE so LATENCY=1 commits on the acceptance edge.
  assign w_st    = w_accept ? mem_write : r_st;
  assign w_f3    = w_accept ? funct3    : r_f3;
  assign w_addr  = w_accept ? addr      : r_addr;
  assign w_wdata = w_accept ? wdata     : r_wdata;
  assign w_bad   = f_bad(w_st, w_f3, w_addr[1:0]);
  assign w_unused_addr = ^w_addr[31:AW+2];

  always_comb begin
    w_next   = r_state;
    stall    = 1'b0;
    done     = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: if (w_req) begin
        stall = 1'b1;
        if (LATENCY == 1) begin
          w_commit = 1'b1;
          w_next   = S_DONE;
        end else begin
          w_next   = S_WAIT;
        end
      end
      // r_cnt = WAIT cycles left; the last one commits and leaves the counter at 0.
      S_WAIT: begin
        stall = 1'b1;
        if (r_cnt <= 4'd1) begin
          w_commit = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign err  = done & w_bad;
  assign w_ld = w_bad ? 32'd0 : (w_st ? r_rdata : f_ext(w_f3, w_addr[1:0], w_q));
  assign rdata = done ? w_ld : r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_st    <= mem_write;
        r_f3    <= funct3;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == S_WAIT) begin
        r_cnt   <= r_cnt - 4'd1;
      end
      if (done) r_rdata <= w_ld;
    end
  end

  dmem_ram_s #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_commit & w_st & ~w_bad & ~rst),
    .i_be    (f_be(w_f3, w_addr[1:0])),
    .i_idx   (w_addr[AW+1:2]),
    .i_wdata (f_lane(w_f3, w_wdata)),
    .o_q     (w_q)
  );
endmodule
